// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
// Imported by the arbiter and its bench.
package mips_mem_pkg;

    localparam int ADDR_W_DEF       = 30;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signals of the unified memory port.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic                  if_ack;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ack, mem_rdata,
        output if_ack, if_rdata,
        output d_ack, d_rdata, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ack, mem_rdata,
        input  if_ack, if_rdata,
        input  d_ack, d_rdata, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t          state_q;
    arb_state_t          state_d;
    grant_t              gnt_q;
    logic [CNT_W-1:0]    starve_q;
    logic                drop_q;
    logic                gnt_if;
    logic                gnt_d;
    logic                busy;

    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // RESP never arbitrates, so a requester can drop req on its ack.
    always_comb begin
        state_d = state_q;
        gnt_if  = 1'b0;
        gnt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && (starve_q < LIMIT || !bus.if_req)) begin
                    gnt_d   = 1'b1;
                    state_d = D_BUSY;
                end else if (bus.if_req) begin
                    gnt_if  = 1'b1;
                    state_d = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ack) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == I_BUSY) || (state_q == D_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= GNT_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (gnt_d) begin
                gnt_q       <= GNT_D;
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                mem_be_q    <= bus.d_be;
            end else if (gnt_if) begin
                gnt_q       <= GNT_IF;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
                mem_be_q    <= '0;
            end
            if (busy && bus.mem_ack) begin
                if (gnt_q == GNT_IF)  if_rdata_q <= bus.mem_rdata;
                else if (!mem_we_q)   d_rdata_q  <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (gnt_if)
                starve_q <= '0;
            else if (gnt_d && bus.if_req && starve_q < LIMIT)
                starve_q <= starve_q + CNT_W'(1);
            if (state_q == RESP)
                drop_q <= 1'b0;
            else if (bus.if_flush && (state_q == I_BUSY || gnt_if))
                drop_q <= 1'b1;
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = (state_q == RESP) && (gnt_q == GNT_IF) && !drop_q;
    assign bus.d_ack     = (state_q == RESP) && (gnt_q == GNT_D);
    assign bus.d_stall   = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable
// memory responder driven from the stimulus process.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    bit          auto_mem;
    int          lat;
    int          wc;
    logic [31:0] rd_val;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory answers after lat extra cycles of mem_req.
    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        if (auto_mem && bus.mem_req) begin
            if (wc == lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd_val;
                wc = 0;
            end else begin
                wc++;
            end
        end
    endtask

    task automatic wait_ack(input bit is_d, input int max, output int n);
        n = 0;
        while (!(is_d ? bus.d_ack : bus.if_ack) && n < max) begin
            step();
            n++;
        end
        chk(is_d ? "d_ack_timeout" : "if_ack_timeout",
            64'(is_d ? bus.d_ack : bus.if_ack), 64'd1);
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_be      = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          ng;
        int          acks;
        int          reqs;
        logic        prev;
        logic [29:0] grants [10];
        logic [31:0] saved;

        idle_inputs();
        auto_mem = 1'b1;
        lat      = 0;
        wc       = 0;
        rd_val   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",  64'(bus.mem_req), 64'd0);
        chk("rst_if_ack",   64'(bus.if_ack), 64'd0);
        chk("rst_d_ack",    64'(bus.d_ack), 64'd0);
        chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
        chk("rst_d_rdata",  64'(bus.d_rdata), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_we",   64'(bus.mem_we), 64'd0);
        chk("rst_d_stall",  64'(bus.d_stall), 64'd0);
        bus.d_req = 1'b1;
        #1;
        chk("rst_d_stall_follow", 64'(bus.d_stall), 64'd1);
        bus.d_req = 1'b0;
        #1;
        rst_n = 1'b1;
        step();

        // Lone fetch, zero-wait memory
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h100;
        rd_val      = 32'h2402000A;
        lat = 0; wc = 0;
        step();
        chk("t1_mem_req_c1", 64'(bus.mem_req), 64'd1);
        chk("t1_mem_addr",   64'(bus.mem_addr), 64'h100);
        chk("t1_mem_we",     64'(bus.mem_we), 64'd0);
        step();
        chk("t1_if_ack",     64'(bus.if_ack), 64'd1);
        chk("t1_if_rdata",   64'(bus.if_rdata), 64'h2402000A);
        chk("t1_mem_req_c2", 64'(bus.mem_req), 64'd0);
        bus.if_req = 1'b0;
        step();
        chk("t1_if_ack_pulse", 64'(bus.if_ack), 64'd0);
        chk("t1_mem_req_c3",   64'(bus.mem_req), 64'd0);

        // Simultaneous fetch and load, 3-cycle memory
        lat = 2; wc = 0;
        rd_val      = 32'h11223344;
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h140;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 30'h200;
        #1;
        chk("t2_stall_c0", 64'(bus.d_stall), 64'd1);
        step();
        chk("t2_mem_addr_d", 64'(bus.mem_addr), 64'h200);
        chk("t2_mem_we",     64'(bus.mem_we), 64'd0);
        chk("t2_stall_c1",   64'(bus.d_stall), 64'd1);
        step();
        chk("t2_stall_c2",   64'(bus.d_stall), 64'd1);
        step();
        chk("t2_stall_c3",   64'(bus.d_stall), 64'd1);
        chk("t2_d_ack_c3",   64'(bus.d_ack), 64'd0);
        step();
        chk("t2_d_ack",      64'(bus.d_ack), 64'd1);
        chk("t2_d_rdata",    64'(bus.d_rdata), 64'h11223344);
        chk("t2_stall_ack",  64'(bus.d_stall), 64'd0);
        bus.d_req = 1'b0;
        rd_val    = 32'h0000ABCD;
        step();
        chk("t2_idle_req",   64'(bus.mem_req), 64'd0);
        step();
        chk("t2_if_grant",   64'(bus.mem_req), 64'd1);
        chk("t2_if_addr",    64'(bus.mem_addr), 64'h140);
        wait_ack(1'b0, 10, n);
        chk("t2_if_lat",     64'(n), 64'd3);
        chk("t2_if_rdata",   64'(bus.if_rdata), 64'h0000ABCD);
        bus.if_req = 1'b0;
        step();

        // Starvation: both held, expect DDDDI DDDDI
        lat = 0; wc = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h380;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 30'h300;
        ng   = 0;
        prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.mem_req && !prev) begin
                if (ng < 10) grants[ng] = bus.mem_addr;
                ng++;
            end
            prev = bus.mem_req;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (4) step();
        chk("t3_ngrants", 64'(ng >= 10), 64'd1);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3_grant%0d", i), 64'(grants[i]),
                (i % 5 == 4) ? 64'h380 : 64'h300);

        // Store with requester inputs changing mid-transaction
        lat = 2; wc = 0;
        rd_val      = 32'h55555555;
        saved       = bus.d_rdata;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 30'h44;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_be    = 4'b0011;
        step();
        chk("t4_mem_req",   64'(bus.mem_req), 64'd1);
        chk("t4_mem_we",    64'(bus.mem_we), 64'd1);
        chk("t4_mem_be",    64'(bus.mem_be), 64'h3);
        chk("t4_mem_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
        chk("t4_mem_addr",  64'(bus.mem_addr), 64'h44);
        bus.d_wdata = '0;
        bus.d_be    = 4'hF;
        bus.d_addr  = 30'h99;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_wdata_hold", 64'(bus.mem_wdata), 64'hDEADBEEF);
            chk("t4_be_hold",    64'(bus.mem_be), 64'h3);
            chk("t4_addr_hold",  64'(bus.mem_addr), 64'h44);
        end
        step();
        chk("t4_d_ack",     64'(bus.d_ack), 64'd1);
        chk("t4_rdata_hold", 64'(bus.d_rdata), 64'(saved));
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();
        chk("t4_d_ack_pulse", 64'(bus.d_ack), 64'd0);

        // Flush one cycle after fetch grant
        lat = 1; wc = 0;
        rd_val      = 32'h77777777;
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h500;
        step();
        chk("t5_mem_req",  64'(bus.mem_req), 64'd1);
        chk("t5_mem_addr", 64'(bus.mem_addr), 64'h500);
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        step();
        bus.if_flush = 1'b0;
        acks = 0;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acks += int'(bus.if_ack);
            reqs += int'(bus.mem_req);
        end
        chk("t5_no_if_ack", 64'(acks), 64'd0);
        chk("t5_no_regrant", 64'(reqs), 64'd0);
        lat = 0; wc = 0;
        rd_val      = 32'hCAFEF00D;
        bus.if_req  = 1'b1;
        bus.if_addr = 30'h600;
        step();
        chk("t5_next_addr", 64'(bus.mem_addr), 64'h600);
        wait_ack(1'b0, 10, n);
        chk("t5_next_rdata", 64'(bus.if_rdata), 64'hCAFEF00D);
        bus.if_req = 1'b0;
        step();

        // Reset during D_BUSY, stray mem_ack afterwards
        auto_mem    = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 30'h700;
        step();
        chk("t6_busy", 64'(bus.mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_drop", 64'(bus.mem_req), 64'd0);
        chk("t6_stall_rst", 64'(bus.d_stall), 64'd1);
        bus.d_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00000BAD;
        acks = 0;
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            acks += int'(bus.if_ack) + int'(bus.d_ack);
            reqs += int'(bus.mem_req);
        end
        chk("t6_no_acks",  64'(acks), 64'd0);
        chk("t6_no_req",   64'(reqs), 64'd0);
        chk("t6_d_rdata",  64'(bus.d_rdata), 64'd0);
        chk("t6_if_rdata", 64'(bus.if_rdata), 64'd0);
        chk("t6_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("t6_mem_we",   64'(bus.mem_we), 64'd0);
        chk("t6_mem_be",   64'(bus.mem_be), 64'd0);
        chk("t6_stall",    64'(bus.d_stall), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch requester (IF, read-only) and the data requester (MEM stage, read/write). It sits between the pipeline's IF/MEM stages and the memory bus, sequences one transaction at a time, and produces the fetch-acknowledge and data-stall signals consumed by the hazard controller. Data requests win by default; a starvation counter guarantees forward progress for fetches.

## Interface

- ADDR_W, 30, word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants with IF pending before IF is forced (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_flush  in  1  pulse: discard result of in-flight fetch
- if_ack  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables (stores)
- d_ack  out  1  one-cycle pulse, d_rdata valid for loads
- d_rdata  out  DATA_W  load data
- d_stall  out  1  d_req & ~d_ack (feeds M_Stall_Controller)
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered transaction fields
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation

- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: if d_req and (starve_cnt < STARVE_LIMIT or !if_req) -> D_BUSY; else if if_req -> I_BUSY; else stay. Transaction fields latch on the grant edge.
- I_BUSY/D_BUSY: mem_req=1; on mem_ack latch mem_rdata -> RESP.
- RESP: exactly one cycle; pulse if_ack or d_ack for the granted side; always -> IDLE. No arbitration in RESP, so a requester sampling its ack can drop req without a spurious re-grant.
- starve_cnt: increments on each data grant while if_req=1, saturates at STARVE_LIMIT, clears on each IF grant.
- Flush: if_flush in I_BUSY (or on the IDLE->I_BUSY edge) sets drop flag; transaction still completes on memory; RESP issues no if_ack; flag clears in RESP. if_flush in RESP or IDLE has no effect.
- mem_ack in IDLE or RESP is ignored (no state change).
- Stores: d_rdata is don't-care, held at previous value.

## Timing

- Reset (async assert, sync deassert in the enclosing reset tree): state=IDLE, starve_cnt=0, drop=0, all outputs 0 (mem_*, if_ack, d_ack, rdata regs, d_stall follows d_req).
- Reset mid-transaction: abandon immediately, mem_req drops the same cycle; a later stray mem_ack is ignored.
- Latency: req seen in cycle 0 -> mem_req in cycle 1 -> mem_ack in cycle k≥1 -> ack in cycle k+1 -> IDLE in k+2, next mem_req at k+3 earliest. Zero-wait memory: 3-cycle request-to-ack, one transaction per 3 cycles.
- Simultaneous if_req/d_req in IDLE: data wins unless starve_cnt==STARVE_LIMIT.
- mem_* fields constant for the whole BUSY state; changes in requester inputs after grant are ignored.

## Structure

- Shared package mips_mem_pkg: arb_state_t enum {IDLE, I_BUSY, D_BUSY, RESP}, grant_t enum {GNT_IF, GNT_D}, default widths.
- Single module; starvation counter and drop flag inline, with no sub-module.

## Test plan

- Lone fetch, addr 0x100, mem_ack in cycle 1 with 0x2402000A -> if_ack in cycle 2, if_rdata=0x2402000A; mem_req high only in cycle 1.
- Simultaneous if_req/d_req (load 0x200, 3-cycle memory) -> data serviced first, d_stall high until d_ack; then fetch granted the cycle after RESP.
- d_req held continuously with if_req pending, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 IF grant, counter back to 0.
- Store d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata stable through BUSY; d_ack single pulse.
- if_flush one cycle after fetch grant -> memory completes, no if_ack; next if_req serviced normally.
- rst_n asserted during D_BUSY, mem_ack arrives after release -> all outputs 0, state IDLE, stray mem_ack ignored, no ack pulses.
